// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter defaults for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_NUM_REQ_DEF   = 4;
    localparam int unsigned ARB_DATA_W_DEF    = 8;
    localparam int unsigned ARB_MAX_BURST_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_id+1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = ARB_NUM_REQ_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               any,
    output logic [ID_W-1:0]    winner_id
);

    logic [ID_W-1:0]      start;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      offset;
    int unsigned          sum;

    // Rotate so the search start sits at bit 0, priority-encode, then rotate back.
    always_comb begin
        start   = (last_id >= ID_W'(NUM_REQ - 1)) ? '0 : last_id + ID_W'(1);
        req_dbl = {req, req};
        rot     = NUM_REQ'(req_dbl >> start);
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = 32'(start) + 32'(offset);
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        winner_id = ID_W'(sum);
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = ARB_NUM_REQ_DEF,
    parameter  int unsigned DATA_W    = ARB_DATA_W_DEF,
    parameter  int unsigned MAX_BURST = ARB_MAX_BURST_DEF,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned       CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             pick_any;
    logic [ID_W-1:0]  pick_id;
    logic             owner_valid;
    logic             beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (req_valid),
        .last_id   (last_id_q),
        .any       (pick_any),
        .winner_id (pick_id)
    );

    // Reset leaves last_id at the top index so producer 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next state plus the combinational handshake and write path of the current owner.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        req_ready   = '0;
        fifo_wr_en  = 1'b0;
        fifo_din    = '0;
        owner_valid = req_valid[grant_id_q];
        beat        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                req_ready[grant_id_q] = !fifo_full;
                beat                  = owner_valid && !fifo_full;
                if (!owner_valid) begin
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end else if (beat) begin
                    fifo_wr_en  = 1'b1;
                    fifo_din    = req_data[32'(grant_id_q)*DATA_W +: DATA_W];
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_id    = grant_id_q;

endmodule
